// File: rtl/dead_time_monitor.sv
// dead_time_monitor: measures the dead time between complementary gate
// commands and flags short dead time and shoot-through.
// Ports: clk_i, rst_i (sync, active-high), gate_a_i/gate_b_i (gate cmds),
//   dt_min_i (min dead time), fault_clr_i (clear sticky flags),
//   dt_meas_o/dt_valid_o (measurement + pulse), dt_viol_o,
//   shoot_through_o (sticky flags), fault_o (OR of flags).
module dead_time_monitor #(
  parameter int DeadTimeWidth = 5
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     gate_a_i,
  input  logic                     gate_b_i,
  input  logic [DeadTimeWidth-1:0] dt_min_i,
  input  logic                     fault_clr_i,
  output logic [DeadTimeWidth-1:0] dt_meas_o,
  output logic                     dt_valid_o,
  output logic                     dt_viol_o,
  output logic                     shoot_through_o,
  output logic                     fault_o
);

  typedef enum logic [2:0] {
    IDLE, ON_A, ON_B, DEAD_A, DEAD_B, OVERLAP
  } state_t;

  localparam logic [DeadTimeWidth-1:0] One = DeadTimeWidth'(1);

  state_t                   state_q, state_d;
  logic [DeadTimeWidth-1:0] cnt_q, cnt_d, cnt_inc;
  logic [DeadTimeWidth-1:0] meas_d;
  logic                     a_q, b_q;
  logic                     valid_d, viol_d, shoot_d;
  logic                     hit, overlap;

  // Counter saturates at all-ones so very long gaps never wrap short.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + One;
  assign overlap = a_q & b_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    meas_d  = dt_meas_o;
    hit     = 1'b0;
    if (overlap) begin
      state_d = OVERLAP;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (a_q)      state_d = ON_A;
          else if (b_q) state_d = ON_B;
        end
        ON_A: begin
          if (b_q) begin
            state_d = ON_B;
            meas_d  = '0;
            hit     = 1'b1;
          end else if (!a_q) begin
            state_d = DEAD_A;
            cnt_d   = One;
          end
        end
        ON_B: begin
          if (a_q) begin
            state_d = ON_A;
            meas_d  = '0;
            hit     = 1'b1;
          end else if (!b_q) begin
            state_d = DEAD_B;
            cnt_d   = One;
          end
        end
        DEAD_A: begin
          if (b_q) begin
            state_d = ON_B;
            meas_d  = cnt_q;
            hit     = 1'b1;
          end else if (a_q) begin
            state_d = ON_A;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        DEAD_B: begin
          if (a_q) begin
            state_d = ON_A;
            meas_d  = cnt_q;
            hit     = 1'b1;
          end else if (b_q) begin
            state_d = ON_B;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        OVERLAP: begin
          if (a_q)      state_d = ON_A;
          else if (b_q) state_d = ON_B;
          else          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    valid_d = hit;
    // A new set condition beats a simultaneous clear.
    if (hit && (meas_d < dt_min_i)) viol_d = 1'b1;
    else if (fault_clr_i)           viol_d = 1'b0;
    else                            viol_d = dt_viol_o;
    if (overlap)          shoot_d = 1'b1;
    else if (fault_clr_i) shoot_d = 1'b0;
    else                  shoot_d = shoot_through_o;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q             <= 1'b0;
      b_q             <= 1'b0;
      state_q         <= IDLE;
      cnt_q           <= '0;
      dt_meas_o       <= '0;
      dt_valid_o      <= 1'b0;
      dt_viol_o       <= 1'b0;
      shoot_through_o <= 1'b0;
    end else begin
      a_q             <= gate_a_i;
      b_q             <= gate_b_i;
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      dt_meas_o       <= meas_d;
      dt_valid_o      <= valid_d;
      dt_viol_o       <= viol_d;
      shoot_through_o <= shoot_d;
    end
  end

  assign fault_o = dt_viol_o | shoot_through_o;

endmodule

// File: doc/dead_time_monitor.md
DEAD_TIME_MONITOR -- requirements
Module: dead_time_monitor

Interface
REQ-001 The module SHALL have parameter DeadTimeWidth, default 5, giving the width of the dead-time counter, threshold and measurement, in clock cycles.
REQ-002 The module SHALL have port clk_i, input, 1 bit: single clock; all logic is rising-edge.
REQ-003 The module SHALL have port rst_i, input, 1 bit: synchronous reset, active-high.
REQ-004 The module SHALL have port gate_a_i, input, 1 bit: gate command, leg A (high-side switch).
REQ-005 The module SHALL have port gate_b_i, input, 1 bit: gate command, leg B (complementary switch).
REQ-006 The module SHALL have port dt_min_i, input, DeadTimeWidth bits: minimum allowed dead time in cycles.
REQ-007 The module SHALL have port fault_clr_i, input, 1 bit: clears the sticky fault flags.
REQ-008 The module SHALL have port dt_meas_o, output, DeadTimeWidth bits: last measured dead time.
REQ-009 The module SHALL have port dt_valid_o, output, 1 bit: one-cycle pulse when dt_meas_o updates.
REQ-010 The module SHALL have port dt_viol_o, output, 1 bit: sticky flag, measured dead time below dt_min_i.
REQ-011 The module SHALL have port shoot_through_o, output, 1 bit: sticky flag, both gates sampled high.
REQ-012 The module SHALL have port fault_o, output, 1 bit: dt_viol_o OR shoot_through_o.

Function
REQ-013 gate_a_i/gate_b_i SHALL be sampled into registers a_q/b_q on every clock edge; the FSM and flags SHALL act on a_q/b_q only, so every output responds on the edge after the sampling edge.
REQ-014 The FSM SHALL have the states IDLE, ON_A, ON_B, DEAD_A (A last on), DEAD_B (B last on), and OVERLAP.
REQ-015 From IDLE, (a_q,b_q)=(1,0) SHALL go to ON_A and (0,1) SHALL go to ON_B, with no measurement; (0,0) SHALL stay in IDLE.
REQ-016 From ON_A, (0,0) SHALL go to DEAD_A with the counter cleared to 1; (1,0) SHALL stay; (0,1) SHALL go to ON_B, measure 0, and assert dt_valid_o.
REQ-017 ON_B SHALL behave as the mirror of ON_A, using DEAD_B.
REQ-018 In DEAD_A, (0,0) SHALL increment the counter, saturating at 2^DeadTimeWidth-1 with no wrap.
REQ-019 In DEAD_A, (0,1) SHALL load dt_meas_o with the counter, pulse dt_valid_o and go to ON_B.
REQ-020 In DEAD_A, (1,0) (same leg re-fires) SHALL go to ON_A with no measurement and no pulse.
REQ-021 DEAD_B SHALL behave as the mirror of DEAD_A.
REQ-022 In any state, (1,1) SHALL set shoot_through_o and go to OVERLAP.
REQ-023 Inside OVERLAP, the FSM SHALL stay while (1,1), go to ON_A on (1,0), go to ON_B on (0,1), and go to IDLE on (0,0); none of these exits SHALL measure.
REQ-024 On every measurement, dt_viol_o SHALL be set if the measured value < dt_min_i, using an unsigned compare of the saturated value; dt_min_i=0 SHALL never flag.
REQ-025 dt_valid_o SHALL be high for exactly one cycle per measurement; dt_meas_o SHALL hold its value between measurements.
REQ-026 fault_clr_i SHALL clear dt_viol_o and shoot_through_o on the next edge.
REQ-027 If fault_clr_i coincides with a new set condition, the set SHALL win.
REQ-028 fault_o SHALL be a combinational OR of the two registered flags.

Reset
REQ-029 While rst_i=1 at an edge, the FSM SHALL go to IDLE, the counter and dt_meas_o SHALL be 0, and dt_valid_o, dt_viol_o, shoot_through_o and fault_o SHALL be 0.
REQ-030 Reset mid-dead-time SHALL discard the partial count, so that the next measurement requires a fresh on-to-off transition.
REQ-031 rst_i SHALL override fault_clr_i and all set conditions.

Verification
REQ-032 Reset then A high 10 cycles, both low 4 cycles, B high, with dt_min_i=3 -> dt_valid_o single pulse, dt_meas_o=4, dt_viol_o=0.
REQ-033 Same sequence with dt_min_i=5 -> dt_meas_o=4, dt_viol_o=1, fault_o=1; then fault_clr_i pulse -> both 0 one edge later.
REQ-034 A falls and B rises on the same edge, with dt_min_i=2 -> dt_meas_o=0, dt_valid_o pulse, dt_viol_o=1.
REQ-035 A high, both low 40 cycles (width 5), B high -> dt_meas_o=31 (saturated), no wrap, dt_viol_o=0 for dt_min_i=31.
REQ-036 A and B both high 1 cycle, then B low -> shoot_through_o=1, state ON_A, no dt_valid_o; fault_clr_i during a second overlap -> shoot_through_o stays 1.
REQ-037 A high, both low 3 cycles, A high again -> no dt_valid_o; rst_i during DEAD_A, then B high -> no dt_valid_o.
